// File: rtl/seq_detect_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// seq_detect_ctrl_pkg
//   Shared definitions for the 1100 detector sequencer: the controller state
//   encoding, default widths and small state-classification helpers.
// ---------------------------------------------------------------------------
package seq_detect_ctrl_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // States in which a run is in progress and the detector is being driven.
  function automatic logic state_is_busy(state_t s);
    return (s == ST_CLEAR) || (s == ST_SHIFT) || (s == ST_DRAIN);
  endfunction

  // The 3-bit register can hold three encodings that name no state.
  function automatic logic state_is_valid(state_t s);
    return (s == ST_IDLE) || state_is_busy(s) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/seq_detect_ctrl.sv
// ---------------------------------------------------------------------------
// seq_detect_ctrl
//   Sequencer for an external 1100 Moore pattern detector. A start in IDLE
//   captures a DATA_W-bit word, the detector is cleared for one cycle, the
//   word is fed MSB-first on det_p1 at one bit per clock, one extra cycle
//   absorbs the detector's Moore latency, and a one-cycle done strobe ends
//   the run. Detector z pulses seen during SHIFT and DRAIN are counted with
//   saturation.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   start        run request, level-sampled in IDLE only
//   abort        cancels a run in CLEAR/SHIFT/DRAIN
//   data_in      test word, captured on an accepted start
//   det_z        Moore output z of the detector
//   det_p1       serial bit to the detector's P1 input
//   det_rst      active-high reset to the detector
//   busy         high in CLEAR, SHIFT and DRAIN
//   done         one-cycle strobe at the end of a completed run
//   match_count  detections in the last run (held until the next start)
// ---------------------------------------------------------------------------
module seq_detect_ctrl
  import seq_detect_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] data_in,
  input  logic              det_z,
  output logic              det_p1,
  output logic              det_rst,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  match_count
);

  localparam int               BIT_W    = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t            state, state_next;
  logic [DATA_W-1:0] shreg, shreg_next;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_next;
  logic [CNT_W-1:0]  count, count_next;
  logic              det_rst_q, det_rst_next;

  // State and datapath registers. det_rst_q comes out of reset high so the
  // detector is held in S0 for as long as reset_n is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      count     <= '0;
      det_rst_q <= 1'b1;
    end else begin
      state     <= state_next;
      shreg     <= shreg_next;
      bit_cnt   <= bit_cnt_next;
      count     <= count_next;
      det_rst_q <= det_rst_next;
    end
  end

  // Next-state and datapath update. The counter update sits after the case
  // so that the abort edge out of SHIFT/DRAIN still counts a z seen there.
  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    bit_cnt_next = bit_cnt;
    count_next   = count;

    case (state)
      ST_IDLE: begin
        if (start) begin
          shreg_next   = data_in;
          count_next   = '0;
          bit_cnt_next = '0;
          state_next   = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        state_next = abort ? ST_IDLE : ST_SHIFT;
      end
      ST_SHIFT: begin
        shreg_next   = {shreg[DATA_W-2:0], 1'b0};
        bit_cnt_next = bit_cnt + 1'b1;
        if (abort) begin
          state_next = ST_IDLE;
        end else if (bit_cnt == LAST_BIT) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_next = abort ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (((state == ST_SHIFT) || (state == ST_DRAIN)) && det_z && (count != CNT_MAX)) begin
      count_next = count + 1'b1;
    end

    // The detector reset is registered so it lines up exactly with CLEAR.
    det_rst_next = (state_next == ST_CLEAR);
  end

  // Outputs decoded from registered state only; an illegal encoding also
  // resets the detector for the single cycle it takes to recover to IDLE.
  assign det_rst     = det_rst_q | ~state_is_valid(state);
  assign det_p1      = (state == ST_SHIFT) & shreg[DATA_W-1];
  assign busy        = state_is_busy(state);
  assign done        = (state == ST_DONE);
  assign match_count = count;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seq_detect_ctrl
//   Bench for seq_detect_ctrl. Two controllers (8-bit/4-bit count and
//   16-bit/2-bit count) each drive a behavioural 1100 Moore detector.
//   Expected match counts come from counting 1100 windows in the word.
// ---------------------------------------------------------------------------
module tb_seq_detect_ctrl;

  localparam int WA = 8;
  localparam int CA = 4;
  localparam int WB = 16;
  localparam int CB = 2;

  logic clk = 1'b0;
  logic reset_n;

  logic          start_a, abort_a, det_z_a, det_p1_a, det_rst_a, busy_a, done_a;
  logic [WA-1:0] data_a;
  logic [CA-1:0] count_a;

  logic          start_b, abort_b, det_z_b, det_p1_b, det_rst_b, busy_b, done_b;
  logic [WB-1:0] data_b;
  logic [CB-1:0] count_b;

  logic [2:0] det_a_s, det_b_s;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  seq_detect_ctrl #(.DATA_W(WA), .CNT_W(CA)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .abort(abort_a),
    .data_in(data_a), .det_z(det_z_a), .det_p1(det_p1_a), .det_rst(det_rst_a),
    .busy(busy_a), .done(done_a), .match_count(count_a)
  );

  seq_detect_ctrl #(.DATA_W(WB), .CNT_W(CB)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .abort(abort_b),
    .data_in(data_b), .det_z(det_z_b), .det_p1(det_p1_b), .det_rst(det_rst_b),
    .busy(busy_b), .done(done_b), .match_count(count_b)
  );

  // Behavioural 1100 Moore detector: state = length of matched prefix,
  // state 4 means a full 1100 was just seen (z=1).
  function automatic logic [2:0] det_next(logic [2:0] s, logic b);
    case (s)
      3'd0:    return b ? 3'd1 : 3'd0;
      3'd1:    return b ? 3'd2 : 3'd0;
      3'd2:    return b ? 3'd2 : 3'd3;
      3'd3:    return b ? 3'd1 : 3'd4;
      default: return b ? 3'd1 : 3'd0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge det_rst_a)
    if (det_rst_a) det_a_s <= 3'd0;
    else           det_a_s <= det_next(det_a_s, det_p1_a);

  always_ff @(posedge clk or posedge det_rst_b)
    if (det_rst_b) det_b_s <= 3'd0;
    else           det_b_s <= det_next(det_b_s, det_p1_b);

  assign det_z_a = (det_a_s == 3'd4);
  assign det_z_b = (det_b_s == 3'd4);

  // Reference: number of (overlapping) 1100 windows in the MSB-first word,
  // saturated at cmax.
  function automatic int model_count(logic [31:0] word, int width, int cmax);
    int n = 0;
    for (int j = 0; j <= width - 4; j++)
      if (word[j+3 -: 4] == 4'b1100) n++;
    return (n > cmax) ? cmax : n;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full run on instance A; checks CLEAR width, bit stream, latency,
  // final count and return to IDLE.
  task automatic run_a(input logic [WA-1:0] w, input string tag);
    int exp_cnt;
    int cyc;
    logic [WA-1:0] seen;
    exp_cnt = model_count(32'(w), WA, (1 << CA) - 1);
    data_a  = w;
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    tests_run++;
    if ({det_rst_a, busy_a} !== 2'b11) begin
      tests_failed++;
      $display("[TB] FAIL %s clear: det_rst,busy got %b required 11", tag, {det_rst_a, busy_a});
    end
    tick;
    tests_run++;
    if (det_rst_a !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL %s clear_width: det_rst in first shift got %b required 0", tag, det_rst_a);
    end
    for (int i = 0; i < WA; i++) begin
      seen[WA-1-i] = det_p1_a;
      if (i < WA - 1) tick;
    end
    cyc = WA + 1;
    while (done_a !== 1'b1 && cyc < 40) begin
      tick;
      cyc++;
    end
    tests_run++;
    if (cyc != WA + 3) begin
      tests_failed++;
      $display("[TB] FAIL %s latency: done after %0d cycles required %0d", tag, cyc, WA + 3);
    end
    tests_run++;
    if (seen !== w) begin
      tests_failed++;
      $display("[TB] FAIL %s p1_stream: got %h required %h", tag, seen, w);
    end
    tests_run++;
    if (count_a !== CA'(exp_cnt)) begin
      tests_failed++;
      $display("[TB] FAIL %s count: got %0d required %0d", tag, count_a, exp_cnt);
    end
    tick;
    tests_run++;
    if ({done_a, busy_a} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL %s idle_after: done,busy got %b required 00", tag, {done_a, busy_a});
    end
  endtask

  task automatic run_b(input logic [WB-1:0] w, input string tag);
    int exp_cnt;
    int cyc;
    logic [WB-1:0] seen;
    exp_cnt = model_count(32'(w), WB, (1 << CB) - 1);
    data_b  = w;
    start_b = 1'b1;
    tick;
    start_b = 1'b0;
    tick;
    for (int i = 0; i < WB; i++) begin
      seen[WB-1-i] = det_p1_b;
      if (i < WB - 1) tick;
    end
    cyc = WB + 1;
    while (done_b !== 1'b1 && cyc < 60) begin
      tick;
      cyc++;
    end
    tests_run++;
    if (cyc != WB + 3) begin
      tests_failed++;
      $display("[TB] FAIL %s latency: done after %0d cycles required %0d", tag, cyc, WB + 3);
    end
    tests_run++;
    if (seen !== w) begin
      tests_failed++;
      $display("[TB] FAIL %s p1_stream: got %h required %h", tag, seen, w);
    end
    tests_run++;
    if (count_b !== CB'(exp_cnt)) begin
      tests_failed++;
      $display("[TB] FAIL %s count: got %0d required %0d", tag, count_b, exp_cnt);
    end
    tick;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; data_a = '0;
    start_b = 1'b0; abort_b = 1'b0; data_b = '0;
    repeat (3) tick;
    tests_run++;
    if ({det_rst_a, det_p1_a, busy_a, done_a, count_a} !== {4'b1000, 4'd0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_hold: rst,p1,busy,done,count got %b,%b,%b,%b,%0d required 1,0,0,0,0",
               det_rst_a, det_p1_a, busy_a, done_a, count_a);
    end
    tests_run++;
    if ({det_rst_b, busy_b, done_b, count_b} !== {3'b100, 2'd0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_hold_b: rst,busy,done,count got %b,%b,%b,%0d required 1,0,0,0",
               det_rst_b, busy_b, done_b, count_b);
    end
    reset_n = 1'b1;
    repeat (3) tick;
    tests_run++;
    if ({det_rst_a, det_p1_a, busy_a, done_a, count_a} !== {4'b0000, 4'd0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_idle: rst,p1,busy,done,count got %b,%b,%b,%b,%0d required 0,0,0,0,0",
               det_rst_a, det_p1_a, busy_a, done_a, count_a);
    end
  endtask

  task automatic test_patterns;
    run_a(8'hCC, "cc");
    run_a(8'hF0, "f0");
    run_a(8'h00, "00");
    run_a(8'hFF, "ff");
  endtask

  task automatic test_random;
    logic [WA-1:0] w;
    logic [WB-1:0] wb;
    for (int i = 0; i < 20; i++) begin
      w = WA'($urandom);
      run_a(w, "rand_a");
    end
    for (int i = 0; i < 6; i++) begin
      wb = WB'($urandom);
      run_b(wb, "rand_b");
    end
  endtask

  task automatic test_saturate;
    run_b(16'hCCCC, "sat");
    run_b(16'hF0F0, "sat2");
  endtask

  task automatic test_abort;
    data_a  = 8'hCC;
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    repeat (3) tick;
    abort_a = 1'b1;
    tick;
    abort_a = 1'b0;
    tests_run++;
    if ({busy_a, done_a, det_rst_a} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL abort_shift: busy,done,det_rst got %b required 000", {busy_a, done_a, det_rst_a});
    end
    tests_run++;
    if (count_a !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL abort_partial: count got %0d required 0", count_a);
    end
    run_a(8'h0C, "after_abort");

    // Abort during CLEAR.
    data_a  = 8'hCC;
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    abort_a = 1'b1;
    tick;
    abort_a = 1'b0;
    tests_run++;
    if ({busy_a, done_a} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL abort_clear: busy,done got %b required 00", {busy_a, done_a});
    end

    // start together with abort in IDLE is accepted.
    start_a = 1'b1;
    abort_a = 1'b1;
    tick;
    start_a = 1'b0;
    abort_a = 1'b0;
    tests_run++;
    if ({busy_a, det_rst_a} !== 2'b11) begin
      tests_failed++;
      $display("[TB] FAIL start_with_abort: busy,det_rst got %b required 11", {busy_a, det_rst_a});
    end
    repeat (12) tick;
  endtask

  task automatic test_back_to_back;
    int cyc;
    bit extra;
    data_a  = 8'hCC;
    start_a = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick;
      tests_run++;
      if (done_a !== ((k % 12) == 11)) begin
        tests_failed++;
        $display("[TB] FAIL b2b_done c%0d: got %b required %b", k, done_a, (k % 12) == 11);
      end
      if ((k % 12) == 11) begin
        tests_run++;
        if (count_a !== 4'd2) begin
          tests_failed++;
          $display("[TB] FAIL b2b_count c%0d: got %0d required 2", k, count_a);
        end
      end
    end
    start_a = 1'b0;
    cyc = 0;
    while (done_a !== 1'b1 && cyc < 30) begin
      tick;
      cyc++;
    end
    tests_run++;
    if (done_a !== 1'b1 || count_a !== 4'd2) begin
      tests_failed++;
      $display("[TB] FAIL b2b_third: done,count got %b,%0d required 1,2", done_a, count_a);
    end
    extra = 1'b0;
    repeat (4) begin
      tick;
      if (busy_a === 1'b1 || done_a === 1'b1) extra = 1'b1;
    end
    tests_run++;
    if (extra !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_stop: unexpected run after start dropped, got %b required 0", extra);
    end

    // start pulsed while busy is ignored, not queued.
    data_a  = 8'hCC;
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    repeat (4) tick;
    data_a  = 8'hFF;
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    cyc = 6;
    while (done_a !== 1'b1 && cyc < 40) begin
      tick;
      cyc++;
    end
    tests_run++;
    if (cyc != 11 || count_a !== 4'd2) begin
      tests_failed++;
      $display("[TB] FAIL busy_start: done cycle,count got %0d,%0d required 11,2", cyc, count_a);
    end
    extra = 1'b0;
    repeat (4) begin
      tick;
      if (busy_a === 1'b1 || done_a === 1'b1) extra = 1'b1;
    end
    tests_run++;
    if (extra !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL busy_start_queued: got %b required 0", extra);
    end

    // Reset in the middle of SHIFT, after one match has been counted.
    data_a  = 8'hCC;
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    repeat (7) tick;
    tests_run++;
    if (count_a !== 4'd1) begin
      tests_failed++;
      $display("[TB] FAIL mid_count: got %0d required 1", count_a);
    end
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({det_rst_a, det_p1_a, busy_a, done_a, count_a} !== {4'b1000, 4'd0}) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset: rst,p1,busy,done,count got %b,%b,%b,%b,%0d required 1,0,0,0,0",
               det_rst_a, det_p1_a, busy_a, done_a, count_a);
    end
    tick;
    reset_n = 1'b1;
    extra = 1'b0;
    repeat (15) begin
      tick;
      if (done_a === 1'b1 || busy_a === 1'b1) extra = 1'b1;
    end
    tests_run++;
    if (extra !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_done: got %b required 0", extra);
    end
  endtask

  initial begin
    test_reset;
    test_patterns;
    test_saturate;
    test_abort;
    test_back_to_back;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule
